// File: rtl/gate_counter_pkg.sv
// Shared widths, reference-frequency constants and target helper for gate_counter.
package gate_counter_pkg;

  localparam int CNT_W = 32;
  localparam int DIV_W = 3;

  localparam logic [CNT_W-1:0] FREQ_BASE_100M = 32'd100_000_000;
  localparam logic [CNT_W-1:0] FREQ_BASE_400M = 32'd400_000_000;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [DIV_W-1:0] div_t;

  // A zero quotient deliberately wraps to all-ones rather than being special-cased.
  function automatic cnt_t calc_target(input cnt_t freq_base, input div_t time_del);
    return (freq_base >> time_del) - cnt_t'(1);
  endfunction

endpackage

// File: rtl/gate_pulse_gen.sv
// Target compare and retriggerable terminal-count pulse of PULSE_LEN cycles.
module gate_pulse_gen
  import gate_counter_pkg::*;
#(
  parameter int PULSE_LEN = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  cnt_t i_q,
  input  cnt_t i_freq_base,
  input  div_t i_time_del,
  output logic o_trig,
  output logic o_cout_b
);

  localparam logic [3:0] LEN_M1 = 4'(PULSE_LEN - 1);

  cnt_t       w_target;
  logic [3:0] r_cnt;
  logic       r_cout_b;

  assign w_target = calc_target(i_freq_base, i_time_del);
  assign o_trig   = (i_q == w_target);
  assign o_cout_b = r_cout_b;

  // r_cnt holds the cycles still owed after the current one; a trigger always reloads it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt    <= 4'd0;
      r_cout_b <= 1'b0;
    end else if (o_trig) begin
      r_cnt    <= LEN_M1;
      r_cout_b <= 1'b1;
    end else if (r_cnt != 4'd0) begin
      r_cnt    <= r_cnt - 4'd1;
      r_cout_b <= 1'b1;
    end else begin
      r_cout_b <= 1'b0;
    end
  end

endmodule

// File: rtl/gate_counter.sv
// Free-running 32-bit gate counter with carry flag and terminal-count pulse.
// Optional macro GATE_AUTOCLR_EN: counter reloads 0 on the target match.
module gate_counter
  import gate_counter_pkg::*;
#(
  parameter int PULSE_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclr,
  input  logic [CNT_W-1:0] freq_base,
  input  logic [DIV_W-1:0] time_del,
  output logic [CNT_W-1:0] q,
  output logic             cout,
  output logic             cout_b
);

`ifdef GATE_AUTOCLR_EN
  localparam bit AUTOCLR_EN = 1'b1;
`else
  localparam bit AUTOCLR_EN = 1'b0;
`endif

  cnt_t r_q;
  logic w_trig;
  logic w_autoclr;

  assign q         = r_q;
  assign cout      = &r_q;
  assign w_autoclr = AUTOCLR_EN && w_trig;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (sclr || w_autoclr) begin
      r_q <= '0;
    end else begin
      r_q <= r_q + cnt_t'(1);
    end
  end

  gate_pulse_gen #(
    .PULSE_LEN (PULSE_LEN)
  ) u_pulse (
    .i_clk       (clk),
    .i_rst       (reset),
    .i_q         (r_q),
    .i_freq_base (freq_base),
    .i_time_del  (time_del),
    .o_trig      (w_trig),
    .o_cout_b    (cout_b)
  );

endmodule

// File: tb/tb_gate_counter.sv
// Randomized bench for gate_counter against a cycle-indexed reference model.
module tb_gate_counter;

`ifdef GATE_AUTOCLR_EN
  localparam bit AUTOCLR = 1'b1;
`else
  localparam bit AUTOCLR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        sclr;
  logic [31:0] freq_base;
  logic [2:0]  time_del;
  logic [31:0] q, q1;
  logic        cout, cout1, cout_b, cout_b1;

  always #5 clk = ~clk;

  gate_counter #(.PULSE_LEN(4)) dut (
    .clk(clk), .reset(reset), .sclr(sclr), .freq_base(freq_base),
    .time_del(time_del), .q(q), .cout(cout), .cout_b(cout_b)
  );

  gate_counter #(.PULSE_LEN(1)) dut1 (
    .clk(clk), .reset(reset), .sclr(sclr), .freq_base(freq_base),
    .time_del(time_del), .q(q1), .cout(cout1), .cout_b(cout_b1)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] m_q;
  longint      cyc = 0;
  longint      last_trig = -1000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse is high for the first L edges counted from the triggering edge.
  function automatic logic pulse_exp(input longint len);
    return (cyc - last_trig) < len;
  endfunction

  task automatic tick();
    logic [31:0] tgt;
    logic        hit;
    tgt = (freq_base >> time_del) - 32'd1;
    hit = (m_q == tgt);
    cyc++;
    if (hit) last_trig = cyc;
    if (sclr) m_q = 32'd0;
    else if (AUTOCLR && hit) m_q = 32'd0;
    else m_q = m_q + 32'd1;
    @(posedge clk);
    #1;
    check("q", q, m_q);
    check("q_len1", q1, m_q);
    check("cout", 32'(cout), 32'(m_q == 32'hFFFF_FFFF));
    check("cout_b", 32'(cout_b), 32'(pulse_exp(4)));
    check("cout_b_len1", 32'(cout_b1), 32'(pulse_exp(1)));
  endtask

  task automatic model_reset();
    m_q = 32'd0;
    last_trig = cyc - 1000;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_q"}, q, 32'd0);
    check({tag, "_cout_b"}, 32'(cout_b), 32'd0);
    check({tag, "_cout_b_len1"}, 32'(cout_b1), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_reset_state("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst_held");
    reset = 1'b0;
  endtask

  task automatic preload(input logic [31:0] v);
    force dut.r_q = v;
    force dut1.r_q = v;
    #1;
    release dut.r_q;
    release dut1.r_q;
    #1;
    m_q = v;
    check("preload_q", q, v);
    check("preload_cout", 32'(cout), 32'(v == 32'hFFFF_FFFF));
  endtask

  initial begin
    reset     = 1'b1;
    sclr      = 1'b0;
    freq_base = 32'd100;
    time_del  = 3'd0;
    #2;
    do_reset();

    // Default pulse window around q = 100..103, then q reaches 110
    repeat (110) tick();
    check("q_after_110", q, 32'd110);

    // Divided target of 24, single-cycle pulse on the short instance
    do_reset();
    freq_base = 32'd100;
    time_del  = 3'd2;
    repeat (30) tick();

    // Small period: autoclear loop when enabled, plain count otherwise
    do_reset();
    freq_base = 32'd10;
    time_del  = 3'd0;
    repeat (35) tick();

    // Reset in the second cycle of a pulse
    do_reset();
    freq_base = 32'd5;
    time_del  = 3'd0;
    repeat (6) tick();
    check("mid_pulse_high", 32'(cout_b), 32'd1);
    reset = 1'b1;
    #2;
    model_reset();
    check_reset_state("mid_pulse_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) tick();

    // Carry flag around the 32-bit wrap
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    freq_base = 32'd100;
    preload(32'hFFFF_FFFE);
    repeat (3) tick();
    check("wrap_q", q, 32'd1);

    // Zero quotient: target wraps to all-ones, trigger only at the wrap edge
    freq_base = 32'd3;
    time_del  = 3'd2;
    preload(32'hFFFF_FFFD);
    repeat (8) tick();

    // Retrigger while high: target 1 with frequent clears
    do_reset();
    freq_base = 32'd2;
    time_del  = 3'd0;
    for (int i = 0; i < 20; i++) begin
      sclr = (i % 3 == 1);
      tick();
    end
    sclr = 1'b0;

    // Randomized operation
    for (int i = 0; i < 2000; i++) begin
      sclr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) begin
        freq_base = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 40));
        time_del  = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 199) == 0) begin
        sclr = 1'b0;
        do_reset();
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/gate_counter.md
GATE_COUNTER -- requirements
Module: gate_counter

Interface
REQ-001 Parameter PULSE_LEN, default 4: the number of clk cycles cout_b stays high per trigger; legal range 1..15.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port sclr, input, 1 bit: synchronous clear of the counter.
REQ-005 Port freq_base, input, 32 bits: reference frequency value, unsigned.
REQ-006 Port time_del, input, 3 bits: right-shift divisor exponent applied to freq_base.
REQ-007 Port q, output, 32 bits: current counter value.
REQ-008 Port cout, output, 1 bit: counter carry-out flag.
REQ-009 Port cout_b, output, 1 bit: terminal-count pulse, registered.

Function
REQ-010 q SHALL increment by 1 on every clk edge, modulo 2^32 (0xFFFF_FFFF wraps to 0).
REQ-011 When sclr=1 at a clk edge, q SHALL load 0; sclr has priority over increment.
REQ-012 cout SHALL be combinational and equal 1 exactly while q == 0xFFFF_FFFF.
REQ-013 target SHALL be (freq_base >> time_del) - 1, computed as 32-bit unsigned.
REQ-014 If freq_base >> time_del == 0, target SHALL wrap to 0xFFFF_FFFF; no special case.
REQ-015 freq_base and time_del SHALL be sampled combinationally each cycle; a change takes effect on the next comparison.
REQ-016 A trigger SHALL occur at any clk edge where the pre-edge q == target, regardless of sclr.
REQ-017 On a trigger, cout_b SHALL go 1 on that edge and stay 1 for exactly PULSE_LEN cycles, then return to 0.
REQ-018 A trigger arriving while cout_b is high SHALL restart the full PULSE_LEN window (retrigger extends the pulse, never shortens it).
REQ-019 With the default free-running counter, cout_b rises on the same edge that q becomes freq_base >> time_del.

Reset
REQ-020 While reset=1: q=0, cout_b=0, and the internal pulse counter is 0, independent of clk.
REQ-021 Reset asserted mid-pulse SHALL terminate the pulse immediately.
REQ-022 After reset deasserts, the first increment SHALL occur on the first clk edge.

Configuration
REQ-023 Macro GATE_AUTOCLR_EN: when defined, an edge with pre-edge q == target SHALL load q=0 instead of incrementing, giving a period of target+1 cycles.
REQ-024 With GATE_AUTOCLR_EN defined, the trigger and cout_b timing are unchanged.
REQ-025 When GATE_AUTOCLR_EN is undefined, the counter wraps only per REQ-010 and REQ-011.

Structure
REQ-026 Package gate_counter_pkg SHALL hold:
- CNT_W=32 and DIV_W=3;
- constants FREQ_BASE_100M=100_000_000 and FREQ_BASE_400M=400_000_000;
- the counter word typedef.
REQ-027 The pulse generator (target compare, retriggerable down-counter) SHALL be a sub-module named gate_pulse_gen, instantiated once.

Verification
REQ-028 Reset, then freq_base=100, time_del=0, run 110 cycles -> cout_b high while q=100..103; low otherwise; q=110.
REQ-029 freq_base=100, time_del=2 (target 24), PULSE_LEN=1 -> a single 1-cycle cout_b coincident with q=25.
REQ-030 GATE_AUTOCLR_EN, freq_base=10, time_del=0 -> q sequence 0..9 repeating; cout_b high 4 cycles starting each time q returns to 0.
REQ-031 Force q to 0xFFFF_FFFE via sclr/preload, run 3 cycles -> cout=1 only while q=0xFFFF_FFFF, then q=0.
REQ-032 Assert reset at the 2nd cycle of a cout_b pulse -> cout_b=0 and q=0 immediately; counting resumes after release.
REQ-033 freq_base=3, time_del=2 (shift=0, target=0xFFFF_FFFF) -> a trigger occurs only at the wrap edge; cout_b rises with q=0.
